// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the control sequencer: opcodes, ALU codes, state encoding.
package control_sequencer_pkg;

   localparam int unsigned IR_W   = 32;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned NREG   = 16;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned STEP_W = 4;
   localparam int unsigned IMM_W  = IR_W - OP_W - 3 * REG_W;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_AND = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [ALU_W-1:0] ALU_SHR = 4'b0100;
   localparam logic [ALU_W-1:0] ALU_SHL = 4'b0101;

   // State codes double as the externally visible step value.
   typedef enum logic [STEP_W-1:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd15
   } state_t;

   // Instruction register field layout.
   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [REG_W-1:0] ra;
      logic [REG_W-1:0] rb;
      logic [REG_W-1:0] rc;
      logic [IMM_W-1:0] imm;
   } ir_t;

   typedef enum logic [2:0] {
      C_ALU, C_ADDI, C_LD, C_ST, C_NOP, C_HALT, C_BAD
   } op_class_t;

   // Group opcodes by the micro-step sequence they follow.
   function automatic op_class_t classify(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: classify = C_ALU;
         OP_ADDI: classify = C_ADDI;
         OP_LD:   classify = C_LD;
         OP_ST:   classify = C_ST;
         OP_NOP:  classify = C_NOP;
         OP_HALT: classify = C_HALT;
         default: classify = C_BAD;
      endcase
   endfunction

   // ALU operation for register-register opcodes.
   function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
      case (op)
         OP_SUB:  alu_code = ALU_SUB;
         OP_AND:  alu_code = ALU_AND;
         OP_OR:   alu_code = ALU_OR;
         OP_SHR:  alu_code = ALU_SHR;
         OP_SHL:  alu_code = ALU_SHL;
         default: alu_code = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_dec.sv
// 4-to-16 one-hot decoder used for the register-file enable vectors.
module dec_4_to_16
   import control_sequencer_pkg::*;
(
   input  logic [REG_W-1:0] sel,
   input  logic             en,
   output logic [NREG-1:0]  onehot
);

   // One bit set at the selected index when enabled, all zero otherwise.
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired micro-step sequencer: fetch T0-T2, execute T3-T7, sticky halt.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [IR_W-1:0]     ir,
   input  logic                mem_ready,
   output logic                PCout,
   output logic                Zlowout,
   output logic                MDRout,
   output logic                Cout,
   output logic                MARin,
   output logic                Zin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                IncPc,
   output logic                read,
   output logic                write,
   output logic [NREG-1:0]     reg_in,
   output logic [NREG-1:0]     reg_out,
   output logic [ALU_W-1:0]    control,
   output logic                halted,
   output logic                illegal,
   output logic [STEP_W-1:0]   step
);

   ir_t              f;
   op_class_t        cls;
   state_t           state;
   state_t           state_next;
   state_t           fetch_st;
   logic             t1_held;
   logic [REG_W-1:0] out_idx;
   logic             out_en;
   logic             in_en;
   logic             unused_imm;

   assign f          = ir_t'(ir);
   assign cls        = classify(f.opcode);
   assign unused_imm = ^f.imm;
   assign fetch_st   = run ? S_T0 : S_IDLE;
   assign step       = STEP_W'(state);
   assign halted     = (state == S_HALT);

   // State register, first-T1-cycle marker and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         t1_held <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_next;
         t1_held <= (state == S_T1) && (state_next == S_T1);
         if ((state == S_T3) && (cls == C_BAD)) begin
            illegal <= 1'b1;
         end
      end
   end

   // Next-state and Moore strobe decode from state and instruction fields.
   always_comb begin
      state_next = state;
      PCout      = 1'b0;
      Zlowout    = 1'b0;
      MDRout     = 1'b0;
      Cout       = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      IncPc      = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      control    = ALU_ADD;
      out_idx    = '0;
      out_en     = 1'b0;
      in_en      = 1'b0;

      case (state)
         S_IDLE: begin
            if (run) state_next = S_T0;
         end
         S_T0: begin
            PCout      = 1'b1;
            MARin      = 1'b1;
            IncPc      = 1'b1;
            Zin        = 1'b1;
            state_next = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = !t1_held;
            read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_next = S_T2;
         end
         S_T2: begin
            MDRout     = 1'b1;
            IRin       = 1'b1;
            state_next = S_T3;
         end
         S_T3: begin
            case (cls)
               C_ALU, C_ADDI, C_LD, C_ST: begin
                  out_idx    = f.rb;
                  out_en     = 1'b1;
                  Yin        = 1'b1;
                  state_next = S_T4;
               end
               C_NOP:   state_next = fetch_st;
               default: state_next = S_HALT;
            endcase
         end
         S_T4: begin
            Zin        = 1'b1;
            state_next = S_T5;
            if (cls == C_ALU) begin
               out_idx = f.rc;
               out_en  = 1'b1;
               control = alu_code(f.opcode);
            end else begin
               Cout = 1'b1;
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
            if ((cls == C_LD) || (cls == C_ST)) begin
               MARin      = 1'b1;
               state_next = S_T6;
            end else begin
               in_en      = 1'b1;
               state_next = fetch_st;
            end
         end
         S_T6: begin
            MDRin = 1'b1;
            if (cls == C_ST) begin
               out_idx    = f.ra;
               out_en     = 1'b1;
               state_next = S_T7;
            end else begin
               read = 1'b1;
               if (mem_ready) state_next = S_T7;
            end
         end
         S_T7: begin
            if (cls == C_ST) begin
               write = 1'b1;
               if (mem_ready) state_next = fetch_st;
            end else begin
               MDRout     = 1'b1;
               in_en      = 1'b1;
               state_next = fetch_st;
            end
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: state_next = S_IDLE;
      endcase
   end

   dec_4_to_16 u_dec_out (
      .sel    (out_idx),
      .en     (out_en),
      .onehot (reg_out)
   );

   dec_4_to_16 u_dec_in (
      .sel    (f.ra),
      .en     (in_en),
      .onehot (reg_in)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized cycle-trace bench: a per-instruction model builds the expected trace up front.
module tb_control_sequencer;
   import control_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;
   logic        PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPc, read, write;
   logic [15:0] reg_in, reg_out;
   logic [3:0]  control;
   logic        halted, illegal;
   logic [3:0]  step;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .MARin(MARin),
      .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPc(IncPc),
      .read(read), .write(write), .reg_in(reg_in), .reg_out(reg_out), .control(control),
      .halted(halted), .illegal(illegal), .step(step)
   );

   // Strobe bit positions in {PCout,Zlowout,MDRout,Cout,MARin,Zin,PCin,MDRin,IRin,Yin,IncPc,read,write}
   localparam logic [12:0] B_PCOUT  = 13'h1000;
   localparam logic [12:0] B_ZLOW   = 13'h0800;
   localparam logic [12:0] B_MDROUT = 13'h0400;
   localparam logic [12:0] B_COUT   = 13'h0200;
   localparam logic [12:0] B_MARIN  = 13'h0100;
   localparam logic [12:0] B_ZIN    = 13'h0080;
   localparam logic [12:0] B_PCIN   = 13'h0040;
   localparam logic [12:0] B_MDRIN  = 13'h0020;
   localparam logic [12:0] B_IRIN   = 13'h0010;
   localparam logic [12:0] B_YIN    = 13'h0008;
   localparam logic [12:0] B_INCPC  = 13'h0004;
   localparam logic [12:0] B_READ   = 13'h0002;
   localparam logic [12:0] B_WRITE  = 13'h0001;

   typedef struct packed {
      logic        rst;
      logic        run;
      logic        mr;
      logic [31:0] ir;
      logic [12:0] strb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [3:0]  ctl;
      logic        hlt;
      logic        ill;
      logic [3:0]  step;
   } vec_t;

   vec_t        q[$];
   logic [31:0] cur_ir;
   logic        m_ill;
   int          n_vec;
   int          n_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] i);
      logic [15:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] alu_of(input logic [4:0] op);
      case (op)
         5'd4:    return 4'b0001;
         5'd5:    return 4'b0010;
         5'd6:    return 4'b0011;
         5'd7:    return 4'b0100;
         5'd8:    return 4'b0101;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic push(input logic [3:0] st, input logic [12:0] s, input logic [15:0] ri,
                       input logic [15:0] ro, input logic [3:0] c, input logic mr,
                       input logic rn, input logic rs);
      vec_t e;
      e.rst  = rs;
      e.run  = rn;
      e.mr   = mr;
      e.ir   = cur_ir;
      e.strb = s;
      e.rin  = ri;
      e.rout = ro;
      e.ctl  = c;
      e.hlt  = (st == 4'd15);
      e.ill  = m_ill;
      e.step = st;
      q.push_back(e);
   endtask

   // Stuck in HALT with random inputs, then reset back to IDLE and request a fetch.
   task automatic halt_tail();
      int k;
      k = $urandom_range(2, 4);
      for (int i = 0; i < k; i++) push(4'd15, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), 1'b1, 1'b0);
      push(4'd15, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b1);
      m_ill = 1'b0;
      push(4'd0, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), 1'b1, 1'b0);
   endtask

   // Expected trace for one instruction starting in T0; fin is run on its last cycle.
   task automatic emit_instr(input logic [31:0] w, input logic fin, input int w1, input int wm);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      int         n;
      cur_ir = w;
      op = w[31:27];
      ra = w[26:23];
      rb = w[22:19];
      rc = w[18:15];
      push(4'd1, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
      for (int i = 0; i <= w1; i++)
         push(4'd2, B_ZLOW | B_READ | B_MDRIN | ((i == 0) ? B_PCIN : 13'h0), 16'h0, 16'h0, 4'h0,
              (i == w1), rnd(), 1'b0);
      push(4'd3, B_MDROUT | B_IRIN, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
            push(4'd4, B_YIN, 16'h0, oh(rb), 4'h0, rnd(), rnd(), 1'b0);
            push(4'd5, B_ZIN, 16'h0, oh(rc), alu_of(op), rnd(), rnd(), 1'b0);
            push(4'd6, B_ZLOW, oh(ra), 16'h0, 4'h0, rnd(), fin, 1'b0);
         end
         5'd12: begin
            push(4'd4, B_YIN, 16'h0, oh(rb), 4'h0, rnd(), rnd(), 1'b0);
            push(4'd5, B_COUT | B_ZIN, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
            push(4'd6, B_ZLOW, oh(ra), 16'h0, 4'h0, rnd(), fin, 1'b0);
         end
         5'd0, 5'd2: begin
            push(4'd4, B_YIN, 16'h0, oh(rb), 4'h0, rnd(), rnd(), 1'b0);
            push(4'd5, B_COUT | B_ZIN, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
            push(4'd6, B_ZLOW | B_MARIN, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
            if (op == 5'd0) begin
               for (int i = 0; i <= wm; i++)
                  push(4'd7, B_READ | B_MDRIN, 16'h0, 16'h0, 4'h0, (i == wm), rnd(), 1'b0);
               push(4'd8, B_MDROUT, oh(ra), 16'h0, 4'h0, rnd(), fin, 1'b0);
            end else begin
               push(4'd7, B_MDRIN, 16'h0, oh(ra), 4'h0, rnd(), rnd(), 1'b0);
               for (int i = 0; i <= wm; i++)
                  push(4'd8, B_WRITE, 16'h0, 16'h0, 4'h0, (i == wm), (i == wm) ? fin : rnd(), 1'b0);
            end
         end
         5'd26: push(4'd4, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), fin, 1'b0);
         5'd27: begin
            push(4'd4, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
            halt_tail();
            return;
         end
         default: begin
            push(4'd4, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), rnd(), 1'b0);
            m_ill = 1'b1;
            halt_tail();
            return;
         end
      endcase
      if (!fin) begin
         n = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) push(4'd0, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), 1'b0, 1'b0);
         push(4'd0, 13'h0, 16'h0, 16'h0, 4'h0, rnd(), 1'b1, 1'b0);
      end
   endtask

   function automatic logic [4:0] pick_op(input int r);
      logic [4:0] legal [10];
      logic [4:0] op;
      legal = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12, 5'd26};
      if (r < 4) begin
         do op = 5'($urandom_range(0, 31));
         while (op inside {5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12, 5'd26, 5'd27});
         return op;
      end
      if (r < 7) return 5'd27;
      return legal[$urandom_range(0, 9)];
   endfunction

   initial begin
      n_vec     = 0;
      n_err     = 0;
      m_ill     = 1'b0;
      cur_ir    = 32'h0;
      reset     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b0;
      ir        = 32'h0;

      // Directed program first, then randomized instructions.
      push(4'd0, 13'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0);
      emit_instr(32'h1891_8000, 1'b1, 0, 0);                        // ADD r1,r2,r3
      emit_instr({5'd0, 4'd4, 4'd5, 4'd0, 15'h0123}, 1'b1, 1, 3);   // LD r4,r5,imm
      emit_instr({5'd2, 4'd6, 4'd1, 4'd0, 15'h0010}, 1'b1, 0, 2);   // ST r6
      emit_instr({5'd4, 4'd7, 4'd8, 4'd9, 15'h0}, 1'b0, 0, 0);      // SUB, run dropped
      emit_instr({5'd12, 4'd15, 4'd0, 4'd0, 15'h7fff}, 1'b1, 2, 0); // ADDI
      emit_instr({5'd31, 27'h0}, 1'b1, 0, 0);                       // illegal opcode
      // Reset while waiting in T1, with run and mem_ready both high on the reset edge.
      cur_ir = {5'd3, 27'h0};
      push(4'd1, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      push(4'd2, B_ZLOW | B_READ | B_MDRIN | B_PCIN, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      push(4'd2, B_ZLOW | B_READ | B_MDRIN, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b1);
      push(4'd0, 13'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         emit_instr({pick_op($urandom_range(0, 99)), 27'($urandom())},
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      emit_instr({5'd27, 27'h0}, 1'b1, 0, 0);                       // HALT

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_step", 64'(step), 64'h0);
      check_eq("reset_strobes", 64'({PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin,
                                     IRin, Yin, IncPc, read, write}), 64'h0);
      check_eq("reset_regs", 64'({reg_in, reg_out, control}), 64'h0);
      check_eq("reset_flags", 64'({halted, illegal}), 64'h0);

      foreach (q[k]) begin
         @(posedge clk);
         #1;
         reset     = q[k].rst;
         run       = q[k].run;
         mem_ready = q[k].mr;
         ir        = q[k].ir;
         @(negedge clk);
         check_eq($sformatf("step[%0d]", k), 64'(step), 64'(q[k].step));
         check_eq($sformatf("strobes[%0d]", k),
                  64'({PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
                       IncPc, read, write}), 64'(q[k].strb));
         check_eq($sformatf("reg_in[%0d]", k), 64'(reg_in), 64'(q[k].rin));
         check_eq($sformatf("reg_out[%0d]", k), 64'(reg_out), 64'(q[k].rout));
         check_eq($sformatf("control[%0d]", k), 64'(control), 64'(q[k].ctl));
         check_eq($sformatf("halted[%0d]", k), 64'(halted), 64'(q[k].hlt));
         check_eq($sformatf("illegal[%0d]", k), 64'(illegal), 64'(q[k].ill));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
